// File: rtl/maxpool_relu_tx_if.sv
// Stream bundle for maxpool_relu_tx: conv1 samples in, pooled samples out.
// The master side is the environment; the pooling stage uses the slave side.
interface maxpool_relu_tx_if #(
  parameter int DATA_W = 12
);
  logic                     valid_in;
  logic                     in_ready;
  logic signed [DATA_W-1:0] conv_out_1;
  logic signed [DATA_W-1:0] conv_out_2;
  logic signed [DATA_W-1:0] conv_out_3;
  logic                     ready_in;
  logic                     valid_out;
  logic signed [DATA_W-1:0] max_value_1;
  logic signed [DATA_W-1:0] max_value_2;
  logic signed [DATA_W-1:0] max_value_3;

  modport master (
    output valid_in, conv_out_1, conv_out_2, conv_out_3, ready_in,
    input  in_ready, valid_out, max_value_1, max_value_2, max_value_3
  );

  modport slave (
    input  valid_in, conv_out_1, conv_out_2, conv_out_3, ready_in,
    output in_ready, valid_out, max_value_1, max_value_2, max_value_3
  );
endinterface

// File: rtl/maxpool_relu_tx.sv
// Streaming 2x2 max-pool + ReLU between conv1 and conv2.
// Holds each pooled sample until accepted; backpressure stalls upstream.
module maxpool_relu_tx #(
  parameter int IN_WIDTH  = 24,
  parameter int IN_HEIGHT = 24,
  parameter int DATA_W    = 12
) (
  input  logic clk,
  input  logic rst,
  maxpool_relu_tx_if.slave bus,
  output logic busy,
  output logic frame_done
);
  localparam int HW   = IN_WIDTH / 2;
  localparam int NOUT = HW * (IN_HEIGHT / 2);
  localparam int CW   = $clog2(IN_WIDTH);
  localparam int RW   = $clog2(IN_HEIGHT);
  localparam int OW   = $clog2(NOUT);
  localparam int LW   = CW - 1;

  typedef logic signed [DATA_W-1:0] smp_t;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic          vld_q, vld_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  smp_t          mv_q [3];
  smp_t          mv_d [3];
  smp_t          h_q  [3];
  smp_t          lb_q [3][HW];
  smp_t          smp  [3];
  smp_t          hmax [3];
  smp_t          vmax [3];
  smp_t          relu [3];
  logic          accept, xfer, emit;
  logic          last_col, last_row, last_out;
  logic [LW-1:0] lidx;

  assign smp[0] = bus.conv_out_1;
  assign smp[1] = bus.conv_out_2;
  assign smp[2] = bus.conv_out_3;

  assign bus.in_ready = !vld_q | bus.ready_in;
  assign accept   = bus.valid_in & bus.in_ready;
  assign xfer     = vld_q & bus.ready_in;
  assign emit     = accept & col_q[0] & row_q[0];
  assign last_col = col_q == CW'(IN_WIDTH - 1);
  assign last_row = row_q == RW'(IN_HEIGHT - 1);
  assign last_out = out_cnt_q == OW'(NOUT - 1);
  assign lidx     = col_q[CW-1:1];

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      hmax[c] = (smp[c] > h_q[c]) ? smp[c] : h_q[c];
      vmax[c] = (lb_q[c][lidx] > hmax[c]) ? lb_q[c][lidx] : hmax[c];
      relu[c] = vmax[c][DATA_W-1] ? '0 : vmax[c];
    end
  end

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    out_cnt_d = out_cnt_q;
    vld_d     = vld_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mv_d      = mv_q;
    if (accept) begin
      col_d = last_col ? '0 : col_q + CW'(1);
      if (last_col)
        row_d = last_row ? '0 : row_q + RW'(1);
    end
    if (xfer) begin
      out_cnt_d = last_out ? '0 : out_cnt_q + OW'(1);
      vld_d     = 1'b0;
      if (last_out) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
    // a new frame's first accept wins over the old frame's final xfer
    if (accept)
      busy_d = 1'b1;
    if (emit) begin
      vld_d = 1'b1;
      mv_d  = relu;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      out_cnt_q <= '0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mv_q      <= '{default: '0};
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      out_cnt_q <= out_cnt_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mv_q      <= mv_d;
    end
  end

  // pair and line storage is always written before it is read
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < 3; c++) begin
        if (!col_q[0])
          h_q[c] <= smp[c];
        else if (!row_q[0])
          lb_q[c][lidx] <= hmax[c];
      end
    end
  end

  assign bus.valid_out   = vld_q;
  assign bus.max_value_1 = mv_q[0];
  assign bus.max_value_2 = mv_q[1];
  assign bus.max_value_3 = mv_q[2];
  assign busy            = busy_q;
  assign frame_done      = done_q;
endmodule
